// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM for a multicycle ARM-style datapath: sequences fetch, decode,
// memory and ALU steps and drives the datapath selects and unconditioned write enables.
module multicycle_ctrl_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic       RegW,
  output logic       MemW,
  output logic       PCS,
  output logic [1:0] FlagW,
  output logic       IllegalOp,
  output logic [3:0] State
);

  localparam int unsigned STATE_W = 4;
  localparam int unsigned CMD_W   = 4;

  typedef enum logic [STATE_W-1:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [CMD_W-1:0] cmd;
  logic             imm;
  logic             set_flags;
  logic             alu_en;

  assign imm       = Funct[5];
  assign cmd       = Funct[4:1];
  assign set_flags = Funct[0];

  // State register; reset returns to FETCH without waiting for an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic; unlisted conditions hold, unused encodings recover to FETCH.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  if (MemReady) state_d = DECODE;
      DECODE: begin
        case (Op)
          2'b01:   state_d = MEMADR;
          2'b00:   state_d = imm ? EXECI : EXECR;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR: state_d = set_flags ? MEMRD : MEMWR;
      MEMRD:  if (MemReady) state_d = MEMWB;
      MEMWR:  if (MemReady) state_d = FETCH;
      EXECR:  state_d = ALUWB;
      EXECI:  state_d = ALUWB;
      MEMWB:  state_d = FETCH;
      ALUWB:  state_d = FETCH;
      BRANCH: state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Moore outputs from the state register, with MemReady-qualified fetch enables.
  always_comb begin
    IRWrite    = 1'b0;
    NextPC     = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 2'b00;
    RegW       = 1'b0;
    MemW       = 1'b0;
    PCS        = 1'b0;
    FlagW      = 2'b00;
    IllegalOp  = 1'b0;
    alu_en     = 1'b0;

    case (state_q)
      FETCH: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        NextPC    = MemReady;
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IllegalOp = (Op == 2'b11);
      end
      MEMADR: ALUSrcB = 2'b01;
      MEMRD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      EXECR: alu_en = 1'b1;
      EXECI: begin
        ALUSrcB = 2'b01;
        alu_en  = 1'b1;
      end
      ALUWB: RegW = 1'b1;
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCS       = 1'b1;
      end
      default: ;
    endcase

    if (alu_en) begin
      case (cmd)
        4'b0100: ALUControl = 2'b00;
        4'b0010: ALUControl = 2'b01;
        4'b0000: ALUControl = 2'b10;
        4'b1100: ALUControl = 2'b11;
        default: ALUControl = 2'b00;
      endcase
      FlagW = {set_flags, set_flags & ((cmd == 4'b0100) || (cmd == 4'b0010))};
    end

    // A register write to R15 is a PC write.
    PCS = PCS | (RegW & (Rd == 4'hF));

    if (!reset) begin
      IRWrite   = 1'b0;
      NextPC    = 1'b0;
      RegW      = 1'b0;
      MemW      = 1'b0;
      PCS       = 1'b0;
      FlagW     = 2'b00;
      IllegalOp = 1'b0;
    end
  end

  assign State = STATE_W'(state_q);

endmodule
